// File: rtl/fifo_sched_pkg.sv
// Shared types and default sizing for the FIFO write-side scheduler.
// Imported by the top level and the arbiter.
package fifo_sched_pkg;

  localparam int DEF_NUM_REQ   = 4;
  localparam int DEF_WIDTH     = 32;
  localparam int DEF_PTR_WIDTH = 6;
  localparam int DEF_NUM_CKPT  = 4;
  localparam int DEF_TAG_WIDTH = 2;

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    RESTORE = 1'b1
  } state_t;

endpackage

// File: rtl/fifo_wr_sched_rr_arbiter.sv
// Round-robin arbiter: the search starts at rr_ptr, and the first requester found is granted.
// After a grant, the pointer moves to the index just past the winner.
module rr_arbiter #(
  parameter int NUM_REQ = fifo_sched_pkg::DEF_NUM_REQ
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               enable,
  output logic [NUM_REQ-1:0] gnt
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] gnt_idx;
  logic [IDX_W-1:0] cand;
  logic             found;
  logic             hit;

  // grant search over requesters in rotated order from rr_ptr
  always_comb begin
    gnt     = '0;
    found   = 1'b0;
    hit     = 1'b0;
    gnt_idx = rr_ptr;
    cand    = rr_ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand       = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
      hit        = enable & ~found & req[cand];
      gnt[cand]  = gnt[cand] | hit;
      gnt_idx    = hit ? cand : gnt_idx;
      found      = found | hit;
    end
  end

  // rotate the priority pointer past the winner; hold when nothing was granted
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rr_ptr <= '0;
    end else if (found) begin
      rr_ptr <= (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
    end else begin
      rr_ptr <= rr_ptr;
    end
  end

endmodule

// File: rtl/fifo_wr_sched.sv
// FIFO write-port scheduler: it arbitrates requesters onto the single write port.
// It also checkpoints the write pointer per branch tag and rolls the pointer back on misprediction.
module fifo_wr_sched
  import fifo_sched_pkg::*;
#(
  parameter int NUM_REQ   = DEF_NUM_REQ,
  parameter int WIDTH     = DEF_WIDTH,
  parameter int PTR_WIDTH = DEF_PTR_WIDTH,
  parameter int NUM_CKPT  = DEF_NUM_CKPT,
  parameter int TAG_WIDTH = DEF_TAG_WIDTH
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       gnt,
  input  logic                     ckpt_en,
  input  logic [TAG_WIDTH-1:0]     ckpt_tag,
  input  logic                     restore_en,
  input  logic [TAG_WIDTH-1:0]     restore_tag,
  output logic                     fifo_w_en,
  output logic [WIDTH-1:0]         fifo_din,
  input  logic [PTR_WIDTH-1:0]     fifo_w_ptr,
  input  logic                     fifo_full,
  input  logic                     fifo_w_fail,
  output logic                     fifo_change_w_ptr_en,
  output logic [PTR_WIDTH-1:0]     fifo_change_w_ptr_value,
  output logic                     recovering,
  output logic                     err
);

  state_t                 state;
  state_t                 state_nxt;
  logic [NUM_CKPT-1:0]    ckpt_vld;
  logic [PTR_WIDTH-1:0]   ckpt_ptr [NUM_CKPT];
  logic [PTR_WIDTH-1:0]   chg_val;
  logic                   err_q;
  logic                   in_run;
  logic                   grant_en;
  logic                   restore_hit;
  logic                   ckpt_take;
  logic                   proto_err;

  assign in_run      = (state == RUN);
  assign grant_en    = reset_n & in_run & ~restore_en & ~fifo_full;
  assign restore_hit = in_run & restore_en & ckpt_vld[restore_tag];
  assign ckpt_take   = in_run & ckpt_en & ~restore_en;
  assign proto_err   = fifo_w_fail
                     | (~in_run & (ckpt_en | restore_en))
                     | (in_run & restore_en & (~ckpt_vld[restore_tag] | ckpt_en));

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req),
    .enable  (grant_en),
    .gnt     (gnt)
  );

  // one-hot grant selects the write data; zero when idle
  always_comb begin
    fifo_din = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      fifo_din = fifo_din | (req_data[i*WIDTH +: WIDTH] & {WIDTH{gnt[i]}});
    end
  end

  assign fifo_w_en = |gnt;

  // next-state: a successful restore spends exactly one cycle in RESTORE
  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     state_nxt = restore_hit ? RESTORE : RUN;
      RESTORE: state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // checkpoint table; the saved pointer already includes this cycle's write
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ckpt_vld <= '0;
      for (int i = 0; i < NUM_CKPT; i++) begin
        ckpt_ptr[i] <= '0;
      end
    end else if (restore_hit) begin
      ckpt_vld <= '0;
    end else if (ckpt_take) begin
      ckpt_vld[ckpt_tag] <= 1'b1;
      ckpt_ptr[ckpt_tag] <= fifo_w_ptr + PTR_WIDTH'(fifo_w_en);
    end else begin
      ckpt_vld <= ckpt_vld;
    end
  end

  // restore target and sticky error
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      chg_val <= '0;
      err_q   <= 1'b0;
    end else begin
      chg_val <= restore_hit ? ckpt_ptr[restore_tag] : chg_val;
      err_q   <= err_q | proto_err;
    end
  end

  // reset during RESTORE must not leak a pointer change to the FIFO
  assign fifo_change_w_ptr_en    = reset_n & (state == RESTORE);
  assign fifo_change_w_ptr_value = chg_val;
  assign recovering              = (state == RESTORE);
  assign err                     = err_q;

endmodule
